// File: rtl/oc8051_tc_if.sv
// SFR bus, run/pin inputs and overflow pulses between the oc8051 core and
// the timer/counter 0/1 block.
interface oc8051_tc_if;
   logic       wr;
   logic [7:0] wr_addr;
   logic [7:0] rd_addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       tr0;
   logic       tr1;
   logic       t0;
   logic       t1;
   logic       int0;
   logic       int1;
   logic       tf0;
   logic       tf1;

   modport master (
      output wr, wr_addr, rd_addr, data_in, tr0, tr1, t0, t1, int0, int1,
      input  data_out, tf0, tf1
   );

   modport slave (
      input  wr, wr_addr, rd_addr, data_in, tr0, tr1, t0, t1, int0, int1,
      output data_out, tf0, tf1
   );
endinterface

// File: rtl/oc8051_tc.sv
// oc8051 timer/counter 0 and 1: TMOD/TLn/THn SFRs, modes 0-3, prescaled tick,
// synchronised pin counting and gating, single-cycle tf0/tf1 overflow pulses.
module oc8051_tc #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic         clk,
   input  logic         rst,
   oc8051_tc_if.slave   bus
);

   localparam logic [7:0] ADDR_TMOD = 8'h89;
   localparam logic [7:0] ADDR_TL0  = 8'h8A;
   localparam logic [7:0] ADDR_TL1  = 8'h8B;
   localparam logic [7:0] ADDR_TH0  = 8'h8C;
   localparam logic [7:0] ADDR_TH1  = 8'h8D;
   localparam logic [7:0] PRE_LAST  = 8'(PRESCALE - 1);

   logic [7:0] tmod_q, tmod_d;
   logic [7:0] tl0_q, tl0_d, th0_q, th0_d;
   logic [7:0] tl1_q, tl1_d, th1_q, th1_d;
   logic [7:0] data_out_q, data_out_d;
   logic       tf0_q, tf0_d, tf1_q, tf1_d;
   logic [7:0] pre_q, pre_d;
   logic [2:0] t0_sync_q, t1_sync_q;
   logic [1:0] int0_sync_q, int1_sync_q;

   logic       tick, ev0, ev1, t0_m3;
   logic       wr_t0, wr_t1, en0, en_th0, en1;
   logic       src0, src1, gate0, gate1;
   logic [1:0] m0, m1;
   logic [16:0] r0, r1;
   logic [8:0] sum_tl0, sum_th0;
   logic       rd_mapped;
   logic [7:0] rd_val;

   // Returns {overflow, th, tl} after one increment in modes 0-2; mode 3 holds.
   function automatic logic [16:0] count_step(input logic [1:0] mode,
                                              input logic [7:0] th,
                                              input logic [7:0] tl);
      logic [13:0] c13;
      logic [16:0] res;
      c13 = '0;
      res = {1'b0, th, tl};
      case (mode)
         2'd0: begin
            c13 = {1'b0, th, tl[4:0]} + 14'd1;
            res = {c13[13], c13[12:5], tl[7:5], c13[4:0]};
         end
         2'd1: res = {1'b0, th, tl} + 17'd1;
         2'd2: res = (tl == 8'hFF) ? {1'b1, th, th} : {1'b0, th, tl + 8'd1};
         default: res = {1'b0, th, tl};
      endcase
      return res;
   endfunction

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? 8'd0 : pre_q + 8'd1;

   // Falling edge seen between the second and third synchroniser flops.
   assign ev0 = t0_sync_q[2] & ~t0_sync_q[1];
   assign ev1 = t1_sync_q[2] & ~t1_sync_q[1];

   assign m0    = tmod_q[1:0];
   assign m1    = tmod_q[5:4];
   assign t0_m3 = (m0 == 2'd3);
   assign src0  = tmod_q[2] ? ev0 : tick;
   assign src1  = tmod_q[6] ? ev1 : tick;
   assign gate0 = ~tmod_q[3] | int0_sync_q[1];
   assign gate1 = ~tmod_q[7] | int1_sync_q[1];

   assign wr_t0 = bus.wr && ((bus.wr_addr == ADDR_TL0) || (bus.wr_addr == ADDR_TH0));
   assign wr_t1 = bus.wr && ((bus.wr_addr == ADDR_TL1) || (bus.wr_addr == ADDR_TH1));

   assign en0    = bus.tr0 & gate0 & src0 & ~wr_t0;
   assign en_th0 = bus.tr1 & tick & ~wr_t0;
   // With timer 0 in mode 3, tr1 belongs to TH0 and timer 1 free-runs.
   assign en1    = (t0_m3 | bus.tr1) & gate1 & src1 & ~wr_t1 & (m1 != 2'd3);

   assign r0      = count_step(m0, th0_q, tl0_q);
   assign r1      = count_step(m1, th1_q, tl1_q);
   assign sum_tl0 = {1'b0, tl0_q} + 9'd1;
   assign sum_th0 = {1'b0, th0_q} + 9'd1;

   always_comb begin
      tmod_d = tmod_q;
      tl0_d  = tl0_q;
      th0_d  = th0_q;
      tl1_d  = tl1_q;
      th1_d  = th1_q;
      tf0_d  = 1'b0;
      tf1_d  = 1'b0;

      if (t0_m3) begin
         if (en0) begin
            tl0_d = sum_tl0[7:0];
            tf0_d = sum_tl0[8];
         end
         if (en_th0) begin
            th0_d = sum_th0[7:0];
            tf1_d = sum_th0[8];
         end
      end else if (en0) begin
         {tf0_d, th0_d, tl0_d} = r0;
      end

      if (en1) begin
         th1_d = r1[15:8];
         tl1_d = r1[7:0];
         if (!t0_m3) tf1_d = r1[16];
      end

      if (bus.wr) begin
         case (bus.wr_addr)
            ADDR_TMOD: tmod_d = bus.data_in;
            ADDR_TL0:  tl0_d  = bus.data_in;
            ADDR_TH0:  th0_d  = bus.data_in;
            ADDR_TL1:  tl1_d  = bus.data_in;
            ADDR_TH1:  th1_d  = bus.data_in;
            default:   ;
         endcase
      end
   end

   always_comb begin
      rd_mapped = 1'b1;
      rd_val    = 8'h00;
      case (bus.rd_addr)
         ADDR_TMOD: rd_val = tmod_q;
         ADDR_TL0:  rd_val = tl0_q;
         ADDR_TH0:  rd_val = th0_q;
         ADDR_TL1:  rd_val = tl1_q;
         ADDR_TH1:  rd_val = th1_q;
         default:   rd_mapped = 1'b0;
      endcase
      data_out_d = rd_val;
      if (bus.wr && (bus.wr_addr == bus.rd_addr) && rd_mapped) data_out_d = bus.data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmod_q      <= 8'h00;
         tl0_q       <= 8'h00;
         th0_q       <= 8'h00;
         tl1_q       <= 8'h00;
         th1_q       <= 8'h00;
         data_out_q  <= 8'h00;
         tf0_q       <= 1'b0;
         tf1_q       <= 1'b0;
         pre_q       <= 8'h00;
         t0_sync_q   <= 3'b000;
         t1_sync_q   <= 3'b000;
         int0_sync_q <= 2'b00;
         int1_sync_q <= 2'b00;
      end else begin
         tmod_q      <= tmod_d;
         tl0_q       <= tl0_d;
         th0_q       <= th0_d;
         tl1_q       <= tl1_d;
         th1_q       <= th1_d;
         data_out_q  <= data_out_d;
         tf0_q       <= tf0_d;
         tf1_q       <= tf1_d;
         pre_q       <= pre_d;
         t0_sync_q   <= {t0_sync_q[1:0], bus.t0};
         t1_sync_q   <= {t1_sync_q[1:0], bus.t1};
         int0_sync_q <= {int0_sync_q[0], bus.int0};
         int1_sync_q <= {int1_sync_q[0], bus.int1};
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.tf0      = tf0_q;
   assign bus.tf1      = tf1_q;

endmodule

// File: tb/tb_oc8051_tc.sv
// Self-checking bench for oc8051_tc: directed mode scenarios plus a randomized
// run against an arithmetic SFR/timer model; a second instance uses PRESCALE=3.
module tb_oc8051_tc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   oc8051_tc_if bus ();
   oc8051_tc_if bus_p ();

   oc8051_tc #(.PRESCALE(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
   oc8051_tc #(.PRESCALE(3)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

   // model state for the randomized run
   logic [7:0] m_tmod, m_tl0, m_th0, m_tl1, m_th1;
   logic       m_i0a, m_i0b, m_i1a, m_i1b;

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.wr = 1'b0;  bus.wr_addr = 8'h00; bus.rd_addr = 8'h00; bus.data_in = 8'h00;
      bus.tr0 = 1'b0; bus.tr1 = 1'b0; bus.t0 = 1'b1; bus.t1 = 1'b1;
      bus.int0 = 1'b0; bus.int1 = 1'b0;
      bus_p.wr = 1'b0;  bus_p.wr_addr = 8'h00; bus_p.rd_addr = 8'h00; bus_p.data_in = 8'h00;
      bus_p.tr0 = 1'b0; bus_p.tr1 = 1'b0; bus_p.t0 = 1'b1; bus_p.t1 = 1'b1;
      bus_p.int0 = 1'b0; bus_p.int1 = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
      bus.wr = 1'b1; bus.wr_addr = a; bus.data_in = d;
      clk_step();
      bus.wr = 1'b0;
   endtask

   task automatic sfr_rd(input logic [7:0] a, output logic [7:0] v);
      bus.rd_addr = a;
      clk_step();
      v = bus.data_out;
   endtask

   // Plain-arithmetic count step for one timer in modes 0..2.
   task automatic adv(input logic [1:0] mode, inout logic [7:0] th,
                      inout logic [7:0] tl, output logic ovf);
      int v;
      ovf = 1'b0;
      case (mode)
         2'd0: begin
            v = int'(th) * 32 + int'(tl[4:0]) + 1;
            if (v == 8192) begin ovf = 1'b1; v = 0; end
            th = 8'(v / 32);
            tl = {tl[7:5], 5'(v % 32)};
         end
         2'd1: begin
            v = int'(th) * 256 + int'(tl) + 1;
            if (v == 65536) begin ovf = 1'b1; v = 0; end
            th = 8'(v / 256);
            tl = 8'(v % 256);
         end
         2'd2: begin
            if (tl == 8'hFF) begin tl = th; ovf = 1'b1; end
            else tl = tl + 8'd1;
         end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      logic [7:0] v;
      logic [7:0] addrs [5] = '{8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D};
      do_reset();
      n_checks++;
      if (bus.data_out !== 8'h00 || bus.tf0 !== 1'b0 || bus.tf1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: data_out=%h tf0=%b tf1=%b, want 00 0 0",
                  bus.data_out, bus.tf0, bus.tf1);
      end
      foreach (addrs[i]) begin
         sfr_rd(addrs[i], v);
         n_checks++;
         if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sfr_%h: got %h want 00", addrs[i], v);
         end
      end
   endtask

   task automatic test_mode1();
      logic [7:0] v;
      do_reset();
      sfr_wr(8'h89, 8'h01); sfr_wr(8'h8C, 8'hFF); sfr_wr(8'h8A, 8'hFE);
      bus.rd_addr = 8'h8A;
      bus.tr0 = 1'b1;
      clk_step();
      n_checks++;
      if (bus.tf0 !== 1'b0) begin n_fail++; $display("FAIL mode1_tf0_e1: got %b want 0", bus.tf0); end
      clk_step();
      bus.tr0 = 1'b0;
      n_checks++;
      if (bus.data_out !== 8'hFF) begin n_fail++; $display("FAIL mode1_tl0_e1: got %h want FF", bus.data_out); end
      n_checks++;
      if (bus.tf0 !== 1'b1) begin n_fail++; $display("FAIL mode1_tf0_e2: got %b want 1", bus.tf0); end
      clk_step();
      n_checks++;
      if (bus.tf0 !== 1'b0) begin n_fail++; $display("FAIL mode1_tf0_e3: got %b want 0", bus.tf0); end
      n_checks++;
      if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL mode1_tl0_wrap: got %h want 00", bus.data_out); end
      sfr_rd(8'h8C, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL mode1_th0_wrap: got %h want 00", v); end
   endtask

   task automatic test_mode2();
      logic [7:0] v, exp_tl;
      logic       exp_tf;
      int         j;
      do_reset();
      sfr_wr(8'h89, 8'h20); sfr_wr(8'h8D, 8'hF0); sfr_wr(8'h8B, 8'hFE);
      bus.rd_addr = 8'h8B;
      bus.tr1 = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         clk_step();
         exp_tf = (k >= 2) && ((k - 2) % 16 == 0);
         n_checks++;
         if (bus.tf1 !== exp_tf) begin
            n_fail++; $display("FAIL mode2_tf1_k%0d: got %b want %b", k, bus.tf1, exp_tf);
         end
         if (k >= 2) begin
            j = k - 1;
            exp_tl = (j == 1) ? 8'hFF : 8'(8'hF0 + (j - 2) % 16);
            n_checks++;
            if (bus.data_out !== exp_tl) begin
               n_fail++; $display("FAIL mode2_tl1_k%0d: got %h want %h", k, bus.data_out, exp_tl);
            end
         end
      end
      bus.tr1 = 1'b0;
      clk_step();
      sfr_rd(8'h8D, v);
      n_checks++;
      if (v !== 8'hF0) begin n_fail++; $display("FAIL mode2_th1_hold: got %h want F0", v); end
   endtask

   task automatic test_mode0();
      logic [7:0] v;
      do_reset();
      sfr_wr(8'h89, 8'h00); sfr_wr(8'h8C, 8'hFF); sfr_wr(8'h8A, 8'hFF);
      bus.tr0 = 1'b1;
      clk_step();
      bus.tr0 = 1'b0;
      n_checks++;
      if (bus.tf0 !== 1'b1) begin n_fail++; $display("FAIL mode0_tf0: got %b want 1", bus.tf0); end
      clk_step();
      n_checks++;
      if (bus.tf0 !== 1'b0) begin n_fail++; $display("FAIL mode0_tf0_off: got %b want 0", bus.tf0); end
      sfr_rd(8'h8A, v);
      n_checks++;
      if (v !== 8'hE0) begin n_fail++; $display("FAIL mode0_tl0: got %h want E0", v); end
      sfr_rd(8'h8C, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL mode0_th0: got %h want 00", v); end
   endtask

   task automatic test_gate_counter();
      logic [7:0] v;
      do_reset();
      sfr_wr(8'h89, 8'h0D);
      bus.tr0 = 1'b1; bus.int0 = 1'b0; bus.rd_addr = 8'h8A;
      repeat (3) clk_step();
      for (int p = 0; p < 3; p++) begin
         bus.t0 = 1'b0; repeat (4) clk_step();
         bus.t0 = 1'b1; repeat (3) clk_step();
      end
      n_checks++;
      if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL gate_blocked: got %h want 00", bus.data_out); end
      bus.int0 = 1'b1;
      repeat (3) clk_step();
      for (int p = 0; p < 3; p++) begin
         bus.t0 = 1'b0;
         repeat (3) clk_step();
         n_checks++;
         if (bus.data_out !== 8'(p)) begin
            n_fail++; $display("FAIL cnt_early_%0d: got %h want %h", p, bus.data_out, 8'(p));
         end
         clk_step();
         n_checks++;
         if (bus.data_out !== 8'(p + 1)) begin
            n_fail++; $display("FAIL cnt_edge3_%0d: got %h want %h", p, bus.data_out, 8'(p + 1));
         end
         bus.t0 = 1'b1; repeat (3) clk_step();
      end
      sfr_rd(8'h8A, v);
      n_checks++;
      if (v !== 8'h03) begin n_fail++; $display("FAIL cnt_total: got %h want 03", v); end
   endtask

   task automatic test_mode3();
      logic [7:0] v;
      do_reset();
      sfr_wr(8'h89, 8'h03); sfr_wr(8'h8D, 8'hFF); sfr_wr(8'h8B, 8'h1F);
      sfr_wr(8'h8A, 8'h33);
      n_checks++;
      if (bus.tf1 !== 1'b0) begin n_fail++; $display("FAIL mode3_t1_no_tf1: got %b want 0", bus.tf1); end
      sfr_wr(8'h8C, 8'hFE);
      bus.rd_addr = 8'h8C;
      bus.tr1 = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         clk_step();
         n_checks++;
         if (bus.tf1 !== (k == 2)) begin
            n_fail++; $display("FAIL mode3_tf1_k%0d: got %b want %b", k, bus.tf1, (k == 2));
         end
         n_checks++;
         if (bus.tf0 !== 1'b0) begin n_fail++; $display("FAIL mode3_tf0_k%0d: got %b want 0", k, bus.tf0); end
      end
      n_checks++;
      if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL mode3_th0: got %h want 00", bus.data_out); end
      bus.tr1 = 1'b0;
      sfr_rd(8'h8A, v);
      n_checks++;
      if (v !== 8'h33) begin n_fail++; $display("FAIL mode3_tl0_static: got %h want 33", v); end
   endtask

   task automatic test_sfr_path();
      logic [7:0] v;
      do_reset();
      bus.rd_addr = 8'h8A;
      bus.wr = 1'b1; bus.wr_addr = 8'h8A; bus.data_in = 8'h55;
      clk_step();
      n_checks++;
      if (bus.data_out !== 8'h55) begin n_fail++; $display("FAIL write_through: got %h want 55", bus.data_out); end
      bus.rd_addr = 8'h80; bus.wr_addr = 8'h80; bus.data_in = 8'hAA;
      clk_step();
      bus.wr = 1'b0;
      n_checks++;
      if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd: got %h want 00", bus.data_out); end
      sfr_wr(8'h89, 8'h01); sfr_wr(8'h8C, 8'hFF); sfr_wr(8'h8A, 8'hFF);
      bus.tr0 = 1'b1;
      bus.wr = 1'b1; bus.wr_addr = 8'h8A; bus.data_in = 8'h10;
      clk_step();
      bus.wr = 1'b0; bus.tr0 = 1'b0;
      n_checks++;
      if (bus.tf0 !== 1'b0) begin n_fail++; $display("FAIL wr_prio_tf0: got %b want 0", bus.tf0); end
      sfr_rd(8'h8A, v);
      n_checks++;
      if (v !== 8'h10) begin n_fail++; $display("FAIL wr_prio_tl0: got %h want 10", v); end
      sfr_rd(8'h8C, v);
      n_checks++;
      if (v !== 8'hFF) begin n_fail++; $display("FAIL wr_prio_th0: got %h want FF", v); end
   endtask

   task automatic test_back_to_back_reset();
      logic [7:0] v;
      logic [7:0] addrs [5] = '{8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D};
      do_reset();
      sfr_wr(8'h89, 8'h02); sfr_wr(8'h8C, 8'hFF); sfr_wr(8'h8A, 8'hFF);
      bus.rd_addr = 8'h8C; bus.tr0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         clk_step();
         n_checks++;
         if (bus.tf0 !== 1'b1) begin n_fail++; $display("FAIL b2b_tf0_%0d: got %b want 1", k, bus.tf0); end
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.tf0 !== 1'b0 || bus.tf1 !== 1'b0 || bus.data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: tf0=%b tf1=%b data_out=%h want 0 0 00", bus.tf0, bus.tf1, bus.data_out);
      end
      bus.tr0 = 1'b0;
      clk_step();
      rst = 1'b0;
      foreach (addrs[i]) begin
         sfr_rd(addrs[i], v);
         n_checks++;
         if (v !== 8'h00) begin n_fail++; $display("FAIL midrun_rst_%h: got %h want 00", addrs[i], v); end
      end
   endtask

   task automatic test_prescale();
      logic [7:0] prev;
      int         n_inc, last;
      do_reset();
      bus_p.rd_addr = 8'h8A;
      bus_p.wr = 1'b1; bus_p.wr_addr = 8'h89; bus_p.data_in = 8'h01;
      clk_step();
      bus_p.wr = 1'b0; bus_p.tr0 = 1'b1;
      clk_step();
      prev = bus_p.data_out; n_inc = 0; last = -1;
      for (int c = 0; c < 39; c++) begin
         clk_step();
         if (bus_p.data_out !== prev) begin
            n_inc++;
            n_checks++;
            if (bus_p.data_out !== prev + 8'd1) begin
               n_fail++; $display("FAIL presc_step: got %h want %h", bus_p.data_out, prev + 8'd1);
            end
            if (last >= 0) begin
               n_checks++;
               if (c - last != 3) begin n_fail++; $display("FAIL presc_gap: got %0d want 3", c - last); end
            end
            last = c;
            prev = bus_p.data_out;
         end
      end
      n_checks++;
      if (n_inc != 13) begin n_fail++; $display("FAIL presc_count: got %0d want 13", n_inc); end
   endtask

   task automatic test_random();
      logic [7:0] n_tmod, n_tl0, n_th0, n_tl1, n_th1, exp_do, a;
      logic       e_tf0, e_tf1, ovf, mapped, en0, en1, g0, g1, wr0, wr1;
      do_reset();
      m_tmod = 8'h00; m_tl0 = 8'h00; m_th0 = 8'h00; m_tl1 = 8'h00; m_th1 = 8'h00;
      m_i0a = 1'b0; m_i0b = 1'b0; m_i1a = 1'b0; m_i1b = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) bus.tr0 = ~bus.tr0;
         if ($urandom_range(0, 7) == 0) bus.tr1 = ~bus.tr1;
         if ($urandom_range(0, 15) == 0) bus.int0 = ~bus.int0;
         if ($urandom_range(0, 15) == 0) bus.int1 = ~bus.int1;
         bus.wr      = ($urandom_range(0, 5) == 0);
         bus.wr_addr = 8'(8'h89 + $urandom_range(0, 4));
         bus.data_in = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         bus.rd_addr = 8'(8'h88 + $urandom_range(0, 6));

         a = bus.rd_addr;
         mapped = (a >= 8'h89) && (a <= 8'h8D);
         case (a)
            8'h89: exp_do = m_tmod;
            8'h8A: exp_do = m_tl0;
            8'h8B: exp_do = m_tl1;
            8'h8C: exp_do = m_th0;
            8'h8D: exp_do = m_th1;
            default: exp_do = 8'h00;
         endcase
         if (bus.wr && bus.wr_addr == a && mapped) exp_do = bus.data_in;

         n_tmod = m_tmod; n_tl0 = m_tl0; n_th0 = m_th0; n_tl1 = m_tl1; n_th1 = m_th1;
         e_tf0 = 1'b0; e_tf1 = 1'b0;
         wr0 = bus.wr && (bus.wr_addr == 8'h8A || bus.wr_addr == 8'h8C);
         wr1 = bus.wr && (bus.wr_addr == 8'h8B || bus.wr_addr == 8'h8D);
         g0  = !m_tmod[3] || m_i0b;
         g1  = !m_tmod[7] || m_i1b;
         // pins held high: counter mode never sees an event
         en0 = bus.tr0 && g0 && !m_tmod[2];
         if (!wr0) begin
            if (m_tmod[1:0] == 2'd3) begin
               if (en0) begin e_tf0 = (n_tl0 == 8'hFF); n_tl0 = n_tl0 + 8'd1; end
               if (bus.tr1) begin e_tf1 = (n_th0 == 8'hFF); n_th0 = n_th0 + 8'd1; end
            end else if (en0) begin
               adv(m_tmod[1:0], n_th0, n_tl0, ovf);
               e_tf0 = ovf;
            end
         end
         en1 = ((m_tmod[1:0] == 2'd3) || bus.tr1) && g1 && !m_tmod[6];
         if (!wr1 && m_tmod[5:4] != 2'd3 && en1) begin
            adv(m_tmod[5:4], n_th1, n_tl1, ovf);
            if (m_tmod[1:0] != 2'd3 && ovf) e_tf1 = 1'b1;
         end
         if (bus.wr) begin
            case (bus.wr_addr)
               8'h89: n_tmod = bus.data_in;
               8'h8A: n_tl0  = bus.data_in;
               8'h8B: n_tl1  = bus.data_in;
               8'h8C: n_th0  = bus.data_in;
               8'h8D: n_th1  = bus.data_in;
               default: ;
            endcase
         end

         clk_step();
         n_checks++;
         if (bus.data_out !== exp_do) begin
            n_fail++; $display("FAIL rand_rd_c%0d: rd=%h got %h want %h", c, a, bus.data_out, exp_do);
         end
         n_checks++;
         if (bus.tf0 !== e_tf0 || bus.tf1 !== e_tf1) begin
            n_fail++;
            $display("FAIL rand_tf_c%0d: got tf0=%b tf1=%b want %b %b", c, bus.tf0, bus.tf1, e_tf0, e_tf1);
         end
         m_tmod = n_tmod; m_tl0 = n_tl0; m_th0 = n_th0; m_tl1 = n_tl1; m_th1 = n_th1;
         m_i0b = m_i0a; m_i0a = bus.int0;
         m_i1b = m_i1a; m_i1a = bus.int1;
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_mode1();
      test_mode2();
      test_mode0();
      test_gate_counter();
      test_mode3();
      test_sfr_path();
      test_back_to_back_reset();
      test_prescale();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
